// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared state encoding, vectors and control-output bundle
package pipe_hazard_ctrl_pkg;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_STALL   = 2'd1;
  localparam logic [1:0] ST_KERNEL  = 2'd2;
  localparam logic [1:0] ST_HOLDOFF = 2'd3;
  localparam logic [31:0] INT_VECTOR = 32'h8000_0004;
  localparam logic [31:0] EXC_VECTOR = 32'h8000_0008;
  localparam logic [4:0]  REG_K0     = 5'd26;
  typedef struct packed {
    logic pc_hold;
    logic if_protect;
    logic if_flush;
    logic id_flush;
    logic inter_take;
    logic except_take;
    logic branch_before_inter;
    logic irq_ack;
  } ctrl_t;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline status in, stall/flush/take controls out
interface pipe_hazard_ctrl_if;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_uses_rt, id_valid, id_jump, id_undef, id_kernel;
  logic ex_mem_rd, ex_branch_taken, irq;
  logic pc_hold, if_protect, if_flush, id_flush;
  logic inter_take, except_take, branch_before_inter, irq_ack;
  modport master (
    input  id_rs, id_rt, ex_rt, id_uses_rt, id_valid, id_jump, id_undef, id_kernel,
           ex_mem_rd, ex_branch_taken, irq,
    output pc_hold, if_protect, if_flush, id_flush, inter_take, except_take,
           branch_before_inter, irq_ack
  );
  modport slave (
    output id_rs, id_rt, ex_rt, id_uses_rt, id_valid, id_jump, id_undef, id_kernel,
           ex_mem_rd, ex_branch_taken, irq,
    input  pc_hold, if_protect, if_flush, id_flush, inter_take, except_take,
           branch_before_inter, irq_ack
  );
endinterface

// File: rtl/pipe_hazard_ctrl_irq_sync.sv
// pipe_hazard_ctrl_irq_sync: IRQ synchroniser, rising-edge detect and pending latch
module pipe_hazard_ctrl_irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic irq_i,
  input  logic ack_i,
  output logic pending_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic edge_q, pending_q, pending_d;
  assign pending_d = (sync_q[SYNC_STAGES-1] & ~edge_q) | (pending_q & ~ack_i);
  assign pending_o = pending_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      edge_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], irq_i};
      edge_q    <= sync_q[SYNC_STAGES-1];
      pending_q <= pending_d;
    end
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall, wrong-path flush and interrupt/exception entry sequencing
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF     = 1,
  parameter int HOLDOFF_W   = 4
) (
  input logic clk,
  input logic rst,
  pipe_hazard_ctrl_if.master bus
);
  logic [1:0] state_q, state_d, ret_q, ret_d, eff_state;
  logic [HOLDOFF_W-1:0] cnt_q, cnt_d;
  logic pending, loaduse, br, exc, intr, stall, jmp, user_valid;
  ctrl_t c;
  pipe_hazard_ctrl_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_irq (
    .clk      (clk),
    .rst      (rst),
    .irq_i    (bus.irq),
    .ack_i    (intr),
    .pending_o(pending)
  );
  assign loaduse = bus.ex_mem_rd & (bus.ex_rt != 5'd0) &
                   ((bus.ex_rt == bus.id_rs) | (bus.id_uses_rt & (bus.ex_rt == bus.id_rt)));
  assign br    = ~rst & bus.ex_branch_taken;
  assign exc   = ~rst & ~br & bus.id_undef & bus.id_valid & (state_q != ST_KERNEL);
  assign intr  = ~rst & ~br & ~exc & pending & bus.id_valid & (state_q == ST_IDLE) &
                 ~bus.id_kernel & ~loaduse;
  assign stall = ~rst & ~br & ~exc & ~intr & loaduse & (state_q != ST_STALL);
  assign jmp   = ~rst & ~br & ~exc & ~intr & ~stall & bus.id_jump & bus.id_valid;
  assign c = '{pc_hold: stall, if_protect: stall, if_flush: br | exc | intr | jmp,
               id_flush: br | stall, inter_take: intr, except_take: exc,
               branch_before_inter: intr, irq_ack: intr};
  assign {bus.pc_hold, bus.if_protect, bus.if_flush, bus.id_flush, bus.inter_take,
          bus.except_take, bus.branch_before_inter, bus.irq_ack} = c;
  // a stalled instruction is re-evaluated next cycle in the state it stalled from
  assign eff_state  = (state_q == ST_STALL) ? ret_q : state_q;
  assign user_valid = bus.id_valid & ~bus.id_kernel;
  always_comb begin
    state_d = eff_state;
    ret_d   = ret_q;
    cnt_d   = cnt_q;
    if (br) state_d = state_q;
    else if (exc | intr) state_d = ST_KERNEL;
    else if (stall) begin
      state_d = ST_STALL;
      ret_d   = state_q;
    end else if (eff_state == ST_KERNEL && user_valid) begin
      state_d = (HOLDOFF == 0) ? ST_IDLE : ST_HOLDOFF;
      cnt_d   = HOLDOFF_W'(HOLDOFF);
    end else if (eff_state == ST_HOLDOFF) begin
      if (cnt_q == '0) state_d = ST_IDLE;
      else if (user_valid & ~jmp) begin
        cnt_d   = cnt_q - HOLDOFF_W'(1);
        state_d = (cnt_q == HOLDOFF_W'(1)) ? ST_IDLE : ST_HOLDOFF;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ret_q   <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for the hazard controller
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pipe_hazard_ctrl_if bus();
  pipe_hazard_ctrl #(.SYNC_STAGES(2), .HOLDOFF(1), .HOLDOFF_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  localparam logic [7:0] NONE  = 8'h00;
  localparam logic [7:0] STALL = 8'hD0;
  localparam logic [7:0] BR    = 8'h30;
  localparam logic [7:0] JMP   = 8'h20;
  localparam logic [7:0] INT   = 8'h2B;
  localparam logic [7:0] EXC   = 8'h24;
  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_t;
  sb_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (ph,prot,iff,idf,int,exc,bbi,ack)", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] outs();
    return {bus.pc_hold, bus.if_protect, bus.if_flush, bus.id_flush, bus.inter_take,
            bus.except_take, bus.branch_before_inter, bus.irq_ack};
  endfunction
  task automatic dflt();
    bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.ex_rt = 5'd0;
    bus.id_uses_rt = 1'b0; bus.id_valid = 1'b1; bus.id_jump = 1'b0;
    bus.id_undef = 1'b0; bus.id_kernel = 1'b0;
    bus.ex_mem_rd = 1'b0; bus.ex_branch_taken = 1'b0;
  endtask
  task automatic lu(input logic [4:0] r);
    bus.ex_mem_rd = 1'b1; bus.ex_rt = r; bus.id_rs = r;
  endtask
  task automatic cyc(input string tag, input logic [7:0] exp);
    sb_t e;
    sb.push_back('{tag, exp});
    @(negedge clk);
    e = sb.pop_front();
    check(e.tag, outs(), e.exp);
    @(posedge clk);
    #1;
  endtask
  task automatic build_pending_in_kernel();
    bus.id_kernel = 1'b1;
    bus.irq = 1'b0;
    repeat (3) cyc("kern_irq_lo", NONE);
    bus.irq = 1'b1;
    repeat (4) cyc("kern_masked", NONE);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
  initial begin
    bus.irq = 1'b0;
    dflt();
    lu(5'd8);
    bus.ex_branch_taken = 1'b1;
    bus.id_undef = 1'b1;
    @(posedge clk);
    #1;
    cyc("rst_quiet0", NONE);
    cyc("rst_quiet1", NONE);
    rst = 1'b0;
    dflt(); lu(5'd8);
    cyc("lu_stall", STALL);
    cyc("lu_one_cycle", NONE);
    dflt();
    cyc("idle", NONE);
    lu(5'd0);
    cyc("lu_r0", NONE);
    bus.ex_mem_rd = 1'b1; bus.ex_rt = 5'd8; bus.id_rs = 5'd3; bus.id_rt = 5'd8;
    cyc("lu_rt_unused", NONE);
    bus.id_uses_rt = 1'b1;
    cyc("lu_rt", STALL);
    dflt();
    cyc("stall_exit", NONE);
    lu(5'd8); bus.ex_branch_taken = 1'b1;
    cyc("br_over_lu", BR);
    bus.ex_branch_taken = 1'b0;
    cyc("lu_after_br", STALL);
    dflt();
    cyc("idle2", NONE);
    bus.id_jump = 1'b1;
    cyc("jump", JMP);
    bus.id_valid = 1'b0;
    cyc("jump_bubble", NONE);
    bus.id_valid = 1'b1; lu(5'd9);
    cyc("jr_lu_stall", STALL);
    cyc("jr_reeval", JMP);
    dflt();
    cyc("idle3", NONE);
    bus.id_undef = 1'b1; bus.id_valid = 1'b0;
    cyc("undef_bubble", NONE);
    bus.id_valid = 1'b1; bus.ex_branch_taken = 1'b1;
    cyc("br_over_undef", BR);
    dflt();
    bus.irq = 1'b1;
    cyc("irq_e0", NONE);
    cyc("irq_e1", NONE);
    cyc("irq_e2", NONE);
    bus.id_jump = 1'b1;
    cyc("irq_take_over_jump", INT);
    dflt(); bus.id_kernel = 1'b1; bus.id_undef = 1'b1;
    cyc("kern_undef_ignored", NONE);
    bus.id_undef = 1'b0;
    lu(5'd4);
    cyc("kern_lu_stall", STALL);
    dflt(); bus.id_kernel = 1'b1;
    cyc("kern_stall_exit", NONE);
    build_pending_in_kernel();
    bus.id_kernel = 1'b0;
    cyc("kern_exit", NONE);
    cyc("holdoff_1", NONE);
    cyc("irq_after_holdoff", INT);
    cyc("kern_exit2", NONE);
    cyc("holdoff_2", NONE);
    repeat (3) cyc("irq_held_no_retrigger", NONE);
    bus.id_undef = 1'b1;
    cyc("undef_exc", EXC);
    bus.id_undef = 1'b0; bus.id_kernel = 1'b1;
    cyc("exc_kernel", NONE);
    rst = 1'b1;
    cyc("rst_mid_kernel", NONE);
    rst = 1'b0; bus.id_kernel = 1'b0; bus.id_undef = 1'b1;
    cyc("post_rst_idle_undef", EXC);
    bus.id_undef = 1'b0;
    build_pending_in_kernel();
    rst = 1'b1; bus.irq = 1'b0;
    cyc("rst_with_pending", NONE);
    rst = 1'b0; bus.id_kernel = 1'b0;
    repeat (3) cyc("post_rst_pending_dropped", NONE);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
